// File: rtl/fir_frame_sequencer_if.sv
// Host and memory-strobe bundle of the FIR frame sequencer.
// The sequencer connects as slave and the host or bench as master.
interface fir_frame_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] len_m1;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] in_addr;
    logic              in_nce;
    logic              in_nwrt;
    logic [ADDR_W-1:0] out_addr;
    logic              out_nce;
    logic              out_nwrt;
    logic              fir_rstn;
    logic              busy;
    logic              done;
    logic              rd_valid;

    modport slave (
        input  start, len_m1, rd_req, rd_addr,
        output in_addr, in_nce, in_nwrt, out_addr, out_nce, out_nwrt,
               fir_rstn, busy, done, rd_valid
    );

    modport master (
        output start, len_m1, rd_req, rd_addr,
        input  in_addr, in_nce, in_nwrt, out_addr, out_nce, out_nwrt,
               fir_rstn, busy, done, rd_valid
    );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Streams a frame from the input memory through the folded FIR into the output
// memory, offset by the filter latency, and serves host read-back between frames.
module fir_frame_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 6
) (
    input  logic                   clk20,
    input  logic                   rstn,
    fir_frame_sequencer_if.slave   seq_if
);
    localparam int K_W = ADDR_W + 4;
    localparam logic [K_W-1:0] LAT_K = K_W'(LATENCY);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [ADDR_W-1:0] n_m1_q, n_m1_d;
    logic              rd_strobe_q, rd_strobe_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic              in_nce_q, in_nce_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_nce_q, out_nce_d;
    logic              out_nwrt_q, out_nwrt_d;
    logic              fir_rstn_q, fir_rstn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [K_W-1:0]    last_in, last_out_d;
    logic [K_W-1:0]    wr_idx;

    assign last_in    = {4'b0000, n_m1_q};
    assign last_out_d = {4'b0000, n_m1_d} + LAT_K;
    assign wr_idx     = k_d - LAT_K;

    // Next state first; the registered outputs then describe the cycle (state_d, k_d).
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_m1_d      = n_m1_q;
        rd_strobe_d = 1'b0;
        in_addr_d   = in_addr_q;
        in_nce_d    = 1'b1;
        out_addr_d  = out_addr_q;
        out_nce_d   = 1'b1;
        out_nwrt_d  = 1'b1;
        fir_rstn_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        rd_valid_d  = rd_strobe_q;

        case (state_q)
            IDLE: begin
                if (seq_if.start) begin
                    state_d = RUN;
                    k_d     = '0;
                    n_m1_d  = seq_if.len_m1;
                end else if (seq_if.rd_req) begin
                    rd_strobe_d = 1'b1;
                    out_addr_d  = seq_if.rd_addr;
                    out_nce_d   = 1'b0;
                end
            end
            RUN: begin
                k_d = k_q + 1'b1;
                if (k_q == last_in) state_d = DRAIN;
            end
            DRAIN: begin
                k_d = k_q + 1'b1;
                if (k_q == last_in + LAT_K) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RUN) begin
            in_addr_d = k_d[ADDR_W-1:0];
            in_nce_d  = 1'b0;
        end
        if (state_d == RUN || state_d == DRAIN) begin
            fir_rstn_d = 1'b1;
            busy_d     = 1'b1;
            if (k_d >= LAT_K && k_d <= last_out_d) begin
                out_addr_d = wr_idx[ADDR_W-1:0];
                out_nce_d  = 1'b0;
                out_nwrt_d = 1'b0;
            end
        end
        if (state_d == DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk20) begin
        if (!rstn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rd_strobe_q <= 1'b0;
            in_addr_q   <= '0;
            in_nce_q    <= 1'b1;
            out_addr_q  <= '0;
            out_nce_q   <= 1'b1;
            out_nwrt_q  <= 1'b1;
            fir_rstn_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rd_strobe_q <= rd_strobe_d;
            in_addr_q   <= in_addr_d;
            in_nce_q    <= in_nce_d;
            out_addr_q  <= out_addr_d;
            out_nce_q   <= out_nce_d;
            out_nwrt_q  <= out_nwrt_d;
            fir_rstn_q  <= fir_rstn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Frame length is only meaningful while a frame runs, so it needs no reset.
    always_ff @(posedge clk20) begin
        n_m1_q <= n_m1_d;
    end

    assign seq_if.in_addr  = in_addr_q;
    assign seq_if.in_nce   = in_nce_q;
    assign seq_if.in_nwrt  = 1'b1;
    assign seq_if.out_addr = out_addr_q;
    assign seq_if.out_nce  = out_nce_q;
    assign seq_if.out_nwrt = out_nwrt_q;
    assign seq_if.fir_rstn = fir_rstn_q;
    assign seq_if.busy     = busy_q;
    assign seq_if.done     = done_q;
    assign seq_if.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Directed bench for fir_frame_sequencer: frame vectors from a table plus
// hand-written reset, read-back and abort sequences.
module tb_fir_frame_sequencer;
    logic clk20 = 1'b0;
    logic rstn;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk20 = ~clk20;

    fir_frame_sequencer_if #(.ADDR_W(8)) bus ();

    fir_frame_sequencer #(.ADDR_W(8), .LATENCY(6)) dut (
        .clk20  (clk20),
        .rstn   (rstn),
        .seq_if (bus)
    );

    typedef struct {
        int len_m1;
        bit inject;
        bit with_rd;
        int first_rd, last_rd, n_rd;
        int first_wr, last_wr, n_wr;
        int busy_first, busy_last;
        int done_c;
    } vec_t;

    localparam logic [23:0] RST_VEC = {8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 4'b0000};

    function automatic logic [23:0] out_vec();
        return {bus.in_addr, bus.in_nce, bus.in_nwrt, bus.out_addr, bus.out_nce,
                bus.out_nwrt, bus.fir_rstn, bus.busy, bus.done, bus.rd_valid};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk20);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int first_rd = 0, last_rd = 0, n_rd = 0;
        int first_wr = 0, last_wr = 0, n_wr = 0;
        int busy_first = 0, busy_last = 0, n_fir = 0;
        int done_c = 0, n_done = 0, n_rv = 0, addr_err = 0, nwrt_err = 0;
        bus.start  = 1'b1;
        bus.len_m1 = 8'(v.len_m1);
        bus.rd_req = v.with_rd;
        bus.rd_addr = 8'd9;
        tick();
        bus.start  = 1'b0;
        bus.rd_req = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (bus.in_nce == 1'b0) begin
                if (first_rd == 0) first_rd = c;
                last_rd = c;
                if (int'(bus.in_addr) != n_rd) addr_err++;
                n_rd++;
            end
            if (bus.out_nce == 1'b0 && bus.out_nwrt == 1'b0) begin
                if (first_wr == 0) first_wr = c;
                last_wr = c;
                if (int'(bus.out_addr) != n_wr) addr_err++;
                n_wr++;
            end
            if (bus.in_nwrt != 1'b1) nwrt_err++;
            if (bus.busy) begin
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (bus.fir_rstn) n_fir++;
            if (bus.rd_valid) n_rv++;
            if (bus.done) begin
                n_done++;
                if (done_c == 0) done_c = c;
            end
            if (done_c != 0 && c > done_c) break;
            if (v.inject && c == 50) begin
                bus.start   = 1'b1;
                bus.rd_req  = 1'b1;
                bus.len_m1  = 8'd3;
                bus.rd_addr = 8'd7;
            end else if (v.inject && c == 51) begin
                bus.start  = 1'b0;
                bus.rd_req = 1'b0;
            end
            tick();
        end
        chk({tag, " first_rd"}, first_rd, v.first_rd);
        chk({tag, " last_rd"}, last_rd, v.last_rd);
        chk({tag, " n_rd"}, n_rd, v.n_rd);
        chk({tag, " first_wr"}, first_wr, v.first_wr);
        chk({tag, " last_wr"}, last_wr, v.last_wr);
        chk({tag, " n_wr"}, n_wr, v.n_wr);
        chk({tag, " busy_first"}, busy_first, v.busy_first);
        chk({tag, " busy_last"}, busy_last, v.busy_last);
        chk({tag, " fir_rstn_cycles"}, n_fir, v.busy_last);
        chk({tag, " done_cycle"}, done_c, v.done_c);
        chk({tag, " done_pulses"}, n_done, 1);
        chk({tag, " addr_errors"}, addr_err, 0);
        chk({tag, " in_nwrt_errors"}, nwrt_err, 0);
        chk({tag, " rd_valid_cycles"}, n_rv, 0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v4;
        int   dn;
        tbl[0] = '{255, 1'b0, 1'b0, 1, 256, 256, 7, 262, 256, 1, 262, 263};
        tbl[1] = '{0,   1'b0, 1'b0, 1, 1,   1,   7, 7,   1,   1, 7,   8};
        tbl[2] = '{99,  1'b1, 1'b0, 1, 100, 100, 7, 106, 100, 1, 106, 107};
        tbl[3] = '{3,   1'b0, 1'b1, 1, 4,   4,   7, 10,  4,   1, 10,  11};
        tbl[4] = '{5,   1'b0, 1'b0, 1, 6,   6,   7, 12,  6,   1, 12,  13};
        tbl[5] = '{2,   1'b0, 1'b0, 1, 3,   3,   7, 9,   3,   1, 9,   10};

        rstn        = 1'b0;
        bus.start   = 1'b1;
        bus.rd_req  = 1'b1;
        bus.len_m1  = 8'd10;
        bus.rd_addr = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset cycle %0d outputs", i), int'(out_vec()), int'(RST_VEC));
        end
        bus.start  = 1'b0;
        bus.rd_req = 1'b0;
        rstn       = 1'b1;
        tick();
        chk("idle after reset outputs", int'(out_vec()), int'(RST_VEC));

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], $sformatf("vec%0d", i));
            tick();
        end

        // Pipelined read-back of addresses 5 and 6.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 8'd5;
        tick();
        chk("rb1 out_addr", int'(bus.out_addr), 5);
        chk("rb1 out_nce", int'(bus.out_nce), 0);
        chk("rb1 out_nwrt", int'(bus.out_nwrt), 1);
        chk("rb1 rd_valid", int'(bus.rd_valid), 0);
        bus.rd_addr = 8'd6;
        tick();
        bus.rd_req = 1'b0;
        chk("rb2 out_addr", int'(bus.out_addr), 6);
        chk("rb2 out_nce", int'(bus.out_nce), 0);
        chk("rb2 out_nwrt", int'(bus.out_nwrt), 1);
        chk("rb2 rd_valid", int'(bus.rd_valid), 1);
        tick();
        chk("rb3 rd_valid", int'(bus.rd_valid), 1);
        chk("rb3 out_nce", int'(bus.out_nce), 1);
        tick();
        chk("rb4 rd_valid", int'(bus.rd_valid), 0);
        chk("rb4 busy", int'(bus.busy), 0);

        // Abort a 256-sample frame at k=100, then run a clean 4-sample frame.
        bus.start  = 1'b1;
        bus.len_m1 = 8'd255;
        tick();
        bus.start = 1'b0;
        dn = 0;
        for (int c = 1; c < 101; c++) begin
            if (bus.done) dn++;
            tick();
        end
        chk("abort in_addr at k=100", int'(bus.in_addr), 100);
        chk("abort out_addr at k=100", int'(bus.out_addr), 94);
        rstn = 1'b0;
        tick();
        chk("abort reset outputs", int'(out_vec()), int'(RST_VEC));
        rstn = 1'b1;
        tick();
        chk("abort idle outputs", int'(out_vec()), int'(RST_VEC));
        chk("abort done pulses", dn, 0);
        v4 = '{3, 1'b0, 1'b0, 1, 4, 4, 7, 10, 4, 1, 10, 11};
        run_frame(v4, "restart");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
